// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding
// and the index-width helper.
package mult_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from R-1 back to 0.
module mult_share_arbiter_rr_arbiter #(
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < R; off++) begin
            pos = (int'(ptr) + off) % R;
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/multiplier_N_bits.sv
// Unsigned combinational N x N multiplier producing the full 2N-bit product.
module multiplier_N_bits #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    assign p = (2*N)'(a) * (2*N)'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier among R requesters: round-robin grant, one operation
// in flight, registered product held on a tagged response channel.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int R   = 4,
    parameter int IDW = clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    output logic [R-1:0]   req_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [2*N-1:0] rsp_p,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    // Handshake: a transfer occurs on a cycle where valid and ready are both
    // high. Requesters may drop valid before a grant; the response side holds
    // rsp_valid/rsp_id/rsp_p stable until rsp_ready is seen.

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*N-1:0] rsp_p_q, rsp_p_d;
    logic           busy_q, busy_d;

    logic [R-1:0]   arb_grant;
    logic [IDW-1:0] arb_idx;
    logic           arb_any;
    logic [2*N-1:0] product;
    logic           grant_window;
    logic           do_grant;

    mult_share_arbiter_rr_arbiter #(
        .R   (R),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    multiplier_N_bits #(
        .N (N)
    ) u_multiplier (
        .a (a_q),
        .b (b_q),
        .p (product)
    );

    // A new grant is possible when idle, or in the same cycle the held
    // response is accepted, which gives one product every two cycles.
    assign grant_window = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp_ready);
    assign do_grant     = grant_window && arb_any;
    assign req_ready    = (do_grant && rst_n) ? arb_grant : '0;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;

        if (do_grant) begin
            a_d   = req_a[arb_idx*N +: N];
            b_d   = req_b[arb_idx*N +: N];
            id_d  = arb_idx;
            ptr_d = (arb_idx == IDW'(R-1)) ? '0 : arb_idx + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (do_grant) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rsp_p_d     = product;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = do_grant ? ST_CALC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: fixed vector table, directed
// corner sequences and randomized traffic against a transaction-level model.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int PW  = 2 * N;
    localparam int W   = IDW + PW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [PW-1:0]  rsp_p;
    logic           busy;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: one slot for an operation being multiplied, one for a
    // product waiting at the output; round-robin pointer over requesters.
    bit             m_calc;
    bit             m_rsp;
    int             m_ptr;
    int             m_a, m_b, m_id;
    int             m_p, m_pid;
    logic [W-1:0]   exp_q[$];

    task automatic model_reset();
        m_calc = 0; m_rsp = 0; m_ptr = 0;
        m_a = 0; m_b = 0; m_id = 0; m_p = 0; m_pid = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int b);
        req_valid[i]     = v;
        req_a[i*N +: N]  = N'(a);
        req_b[i*N +: N]  = N'(b);
    endtask

    // One clock of model-checked operation; inputs are already applied.
    task automatic step();
        bit           can;
        int           w;
        int           idx;
        int           ga, gb;
        logic [R-1:0] er;
        logic [W-1:0] front;
        bit           accept;
        @(negedge clk);
        can = !m_calc && (!m_rsp || rsp_ready);
        w = -1;
        if (can) begin
            for (int off = 0; off < R; off++) begin
                idx = (m_ptr + off) % R;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        er = (w >= 0) ? R'(1 << w) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        chk("busy", 32'(busy), 32'(m_calc || m_rsp));
        if (m_rsp) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_pid));
            chk("rsp_p", 32'(rsp_p), 32'(m_p));
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                front = exp_q.pop_front();
                chk("sb_order", 32'({rsp_id, rsp_p}), 32'(front));
            end
        end
        ga = 0; gb = 0;
        if (w >= 0) begin
            ga = int'(req_a[w*N +: N]);
            gb = int'(req_b[w*N +: N]);
        end
        accept = m_rsp && rsp_ready;
        @(posedge clk);
        #1;
        if (accept) m_rsp = 0;
        if (m_calc) begin
            m_rsp = 1;
            m_p   = m_a * m_b;
            m_pid = m_id;
        end
        m_calc = (w >= 0);
        if (w >= 0) begin
            m_a   = ga;
            m_b   = gb;
            m_id  = w;
            m_ptr = (w + 1) % R;
            exp_q.push_back({IDW'(w), PW'(ga * gb)});
        end
    endtask

    typedef struct {
        bit             rst;
        logic [R-1:0]   valid;
        logic [R*N-1:0] a;
        logic [R*N-1:0] b;
        logic           rready;
        logic [R-1:0]   e_ready;
        logic           e_rv;
        logic [IDW-1:0] e_id;
        logic [PW-1:0]  e_p;
        logic           e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit rst, input logic [R-1:0] valid, input logic [R*N-1:0] a,
                           input logic [R*N-1:0] b, input logic rready, input logic [R-1:0] e_ready,
                           input logic e_rv, input logic [IDW-1:0] e_id, input logic [PW-1:0] e_p,
                           input logic e_busy);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a = a; v.b = b; v.rready = rready;
        v.e_ready = e_ready; v.e_rv = e_rv; v.e_id = e_id; v.e_p = e_p; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Single requester 0: 3*5, then four requesters with a_i=i+1, b=15.
        add_vec(1, 4'b0001, 16'h0003, 16'h0005, 1, 4'b0001, 0, 0, 8'd0,  0);
        add_vec(0, 4'b0000, 16'h0003, 16'h0005, 1, 4'b0000, 0, 0, 8'd0,  1);
        add_vec(0, 4'b0000, 16'h0003, 16'h0005, 1, 4'b0000, 1, 0, 8'd15, 1);
        add_vec(0, 4'b0000, 16'h0003, 16'h0005, 1, 4'b0000, 0, 0, 8'd15, 0);
        add_vec(1, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0001, 0, 0, 8'd0,  0);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0000, 0, 0, 8'd0,  1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0010, 1, 0, 8'd15, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0000, 0, 0, 8'd15, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0100, 1, 1, 8'd30, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0000, 0, 1, 8'd30, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b1000, 1, 2, 8'd45, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0000, 0, 2, 8'd45, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0001, 1, 3, 8'd60, 1);
        add_vec(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0000, 0, 3, 8'd60, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            rsp_ready = vecs[i].rready;
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].e_id));
            chk($sformatf("vec%0d_rsp_p", i), 32'(rsp_p), 32'(vecs[i].e_p));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            @(posedge clk);
            #1;
        end

        // Back-pressure: product held, no grants while blocked, then same-cycle regrant.
        do_reset();
        set_req(2, 1, 15, 15);
        set_req(3, 0, 4, 4);
        step();
        req_valid = 4'b1011;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("hold_rsp_p", 32'(rsp_p), 32'd225);
            chk("hold_rsp_id", 32'(rsp_id), 32'd2);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("hold_regrant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();

        // Pointer wrap from 3 to 0, and a zero operand.
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 1, 1, 1);
        step();
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        set_req(0, 1, 0, 9);
        set_req(2, 1, 2, 3);
        #1;
        chk("wrap_grant0", 32'(req_ready), 32'b0001);
        step();
        step();
        chk("wrap_grant2", 32'(req_ready), 32'b0100);
        chk("zero_product", 32'(rsp_p), 32'd0);
        step();
        req_valid = '0;
        step();
        chk("wrap_product2", 32'(rsp_p), 32'd6);
        for (int k = 0; k < 3; k++) step();

        // Reset during CALC abandons the operation.
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1, 5, 5);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_rsp_p", 32'(rsp_p), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        set_req(1, 1, 2, 2);
        set_req(3, 1, 3, 3);
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();

        // Operand changes after the grant cycle are ignored.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1, 7, 9);
        step();
        set_req(0, 0, 1, 1);
        step();
        chk("late_operand_p", 32'(rsp_p), 32'd63);
        step();
        step();

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < R; i++) begin
                set_req(i, ($urandom_range(0, 99) < 55), $urandom_range(0, 15), $urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 99) < 65);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
